period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Measures a slow square-wave input in units of `clkin` cycles; the receive-side counterpart to the design's clock dividers.
- Synchronises the input, detects edges, and counts cycles between consecutive rising edges (period) and from rise to fall (high time).
- Presents each completed measurement on a valid/ready output.
- Used to calibrate and self-check divided clocks and slow external strobes, e.g. key/rotor step signals.

Parameters:
- CNT_W, 32, width of all counters and result fields.
- TIMEOUT, 1000000, cycles without a qualifying edge before the measurement is abandoned; legal range 2..2^CNT_W-1.

Ports:
- clkin  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sig_in  in  1  asynchronous slow input to measure.
- meas_period  out  CNT_W  cycles between last two rising edges.
- meas_high  out  CNT_W  cycles from first of those rises to the intervening fall.
- meas_valid  out  1  result available.
- meas_ready  in  1  consumer accepts result.
- dropped  out  1  sticky: a result was overwritten unaccepted; cleared on handshake.
- timeout  out  1  one-cycle pulse when TIMEOUT expires.

Behaviour:
- Reset values: one clock `clkin`; reset is asynchronous and active-low (`rst_n`). Asserting `rst_n` low immediately clears all state: sync flops 0, `cnt` 0, FSM IDLE, `meas_period` 0, `meas_high` 0, `meas_valid` 0, `dropped` 0, `timeout` 0.
- Sync and edge detect:
  - Two-flop synchroniser gives `s`; one more flop gives `s_q`.
  - `rise` = `s & ~s_q`; `fall` = `~s & s_q`.
  - `rise` occurs 3 `clkin` edges after `sig_in` goes high. Edge-to-edge spacing is preserved, so this latency does not affect results.
- Counter:
  - On `rise`: `cnt` <= 1. Otherwise: `cnt` <= `cnt` + 1, saturating at 2^CNT_W-1.
  - At a `rise` or `fall` cycle, `cnt` equals the cycles elapsed since the previous `rise`.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: `rise` -> HIGH. The first edge after reset or timeout only arms the meter; no result is produced.
  - HIGH: `fall` -> LOW, latch `hi_tmp` <= `cnt`.
  - LOW: `rise` -> HIGH, publish the result (see Result publish).
  - HIGH or LOW with `cnt` == TIMEOUT and no edge this cycle -> IDLE, `timeout` = 1 for exactly one cycle, no result published.
  - `rise` while in HIGH cannot occur (edges alternate after sync); it is handled as a fresh arm: stay HIGH, restart `cnt`.
- Result publish:
  - `meas_period` <= `cnt`, `meas_high` <= `hi_tmp`, `meas_valid` <= 1.
  - If `meas_valid` was 1 and `meas_ready` was 0 that cycle, set `dropped` <= 1.
  - Publish with a simultaneous handshake: the new result wins, `meas_valid` stays 1, `dropped` is not set.
- Handshake:
  - Transfer occurs when `meas_valid` & `meas_ready` on a `clkin` edge.
  - After transfer, `meas_valid` <= 0 unless a publish occurs in the same cycle.
  - Transfer clears `dropped`, except when a publish in the same cycle sets it.
  - `meas_period` and `meas_high` are stable while `meas_valid` is 1 and no publish occurs.
- Width rules:
  - `meas_period` ≥ 2 for any published result.
  - `meas_high` < `meas_period`.
  - The counter saturates and never wraps; TIMEOUT ≤ max guarantees that timeout fires first.
- Reset mid-measurement: results are discarded and the meter re-arms on the next rise.

Decomposition:
- Shared package: FSM state encoding (IDLE/HIGH/LOW as 2-bit constants) and the default CNT_W.
- One natural sub-module: `sync_edge_detect` (2-flop sync + delay flop, outputs `s`, `rise`, `fall`; asynchronous active-low reset). It is reusable for key inputs.
- Counter, FSM and output register stay in `period_meter`.

Test Plan:
- Square wave, period 10000 `clkin` cycles, 50% duty, `meas_ready`=1 -> first rise gives no result; each later rise publishes `meas_period`=10000, `meas_high`=5000, `meas_valid` one-cycle pulses, `dropped`=0.
- Asymmetric wave, high 3 / low 5 cycles -> `meas_period`=8, `meas_high`=3 every period.
- Same 10000-cycle wave, `meas_ready`=0 for two periods -> second publish sets `dropped`=1 and `meas_period` holds the latest value; `meas_ready`=1 for one cycle -> `meas_valid`=0, `dropped`=0.
- TIMEOUT=100, `sig_in` rises then stays high -> `timeout` pulses once, exactly 100 cycles after `rise`; FSM returns to IDLE, no publish; the next two rises 40 cycles apart yield `meas_period`=40.
- `rst_n` low for 1 cycle mid-period -> all outputs 0 immediately (asynchronously); the first post-reset rise produces no result, the second gives the correct period.
- Publish coinciding with a `meas_ready` handshake -> new value presented, `meas_valid` stays 1, `dropped` stays 0.

Source files
------------

// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared FSM encoding and default counter width for period_meter.
package period_meter_pkg;
    localparam int CNT_W_DEF = 32;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: two-flop synchroniser plus delay flop with rise/fall strobes.
//   clkin, rst_n : clock, asynchronous active-low reset
//   d            : asynchronous input
//   s            : synchronised level
//   rise, fall   : one-cycle edge strobes of s
module sync_edge_detect (
    input  logic clkin,
    input  logic rst_n,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);
    logic meta, s_q;
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) {meta, s, s_q} <= '0;
        else        {meta, s, s_q} <= {d, meta, s};
    end
    assign rise = s & ~s_q;
    assign fall = ~s & s_q;
endmodule

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow input in clkin cycles.
//   clkin, rst_n            : clock, asynchronous active-low reset
//   sig_in                  : asynchronous input to measure
//   meas_period, meas_high  : last completed measurement
//   meas_valid, meas_ready  : result handshake
//   dropped                 : sticky, a result was overwritten before acceptance
//   timeout                 : one-cycle pulse when a measurement is abandoned
module period_meter
    import period_meter_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT = 1000000
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             dropped,
    output logic             timeout
);
    logic s_unused, rise, fall;
    logic [CNT_W-1:0] cnt, hi_tmp;
    state_t state, state_d;
    logic publish, latch_hi, expire, xfer, idle_long;

    sync_edge_detect u_sync (
        .clkin(clkin),
        .rst_n(rst_n),
        .d    (sig_in),
        .s    (s_unused),
        .rise (rise),
        .fall (fall)
    );

    // Cycles since the last rise; saturates so it can never wrap into a short period.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n)          cnt <= '0;
        else if (rise)       cnt <= CNT_W'(1);
        else if (cnt != '1)  cnt <= cnt + CNT_W'(1);
    end

    // >= rather than == so an edge landing exactly on the limit still times out next cycle.
    assign idle_long = !(rise || fall) && cnt >= TIMEOUT;
    assign xfer      = meas_valid & meas_ready;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d  = state;
        publish  = 1'b0;
        latch_hi = 1'b0;
        expire   = 1'b0;
        case (state)
            IDLE: if (rise) state_d = HIGH;
            HIGH: begin
                if (fall) begin
                    state_d  = LOW;
                    latch_hi = 1'b1;
                end else if (idle_long) begin
                    state_d = IDLE;
                    expire  = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                    publish = 1'b1;
                end else if (idle_long) begin
                    state_d = IDLE;
                    expire  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            hi_tmp      <= '0;
            meas_period <= '0;
            meas_high   <= '0;
            meas_valid  <= 1'b0;
            dropped     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= expire;
            if (latch_hi) hi_tmp <= cnt;
            if (publish) begin
                meas_period <= cnt;
                meas_high   <= hi_tmp;
            end
            meas_valid <= publish | (meas_valid & ~meas_ready);
            // A publish onto an unaccepted result marks it dropped; a plain transfer clears it.
            dropped    <= (publish & meas_valid & ~meas_ready) | (dropped & ~xfer);
        end
    end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed self-checking bench for period_meter.
module tb_period_meter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sig_in = 1'b0, meas_ready = 1'b1;
    logic [31:0] meas_period, meas_high;
    logic meas_valid, dropped, timeout;
    logic sig_t = 1'b0, ready_t = 1'b1;
    logic [15:0] period_t, high_t;
    logic valid_t, dropped_t, timeout_t;

    int nvec = 0, nerr = 0;
    int nvalid, ndrop, nto;
    logic [31:0] last_p, last_h;

    period_meter #(.CNT_W(32), .TIMEOUT(32'd20000)) dut (
        .clkin(clk), .rst_n(rst_n), .sig_in(sig_in),
        .meas_period(meas_period), .meas_high(meas_high),
        .meas_valid(meas_valid), .meas_ready(meas_ready),
        .dropped(dropped), .timeout(timeout)
    );

    period_meter #(.CNT_W(16), .TIMEOUT(16'd100)) dut_t (
        .clkin(clk), .rst_n(rst_n), .sig_in(sig_t),
        .meas_period(period_t), .meas_high(high_t),
        .meas_valid(valid_t), .meas_ready(ready_t),
        .dropped(dropped_t), .timeout(timeout_t)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic lvl, input int n);
        sig_in = lvl;
        repeat (n) begin
            @(negedge clk);
            if (meas_valid) begin nvalid++; last_p = meas_period; last_h = meas_high; end
            if (dropped) ndrop++;
            if (timeout) nto++;
        end
    endtask

    task automatic drive_t(input logic lvl, input int n);
        sig_t = lvl;
        repeat (n) begin
            @(negedge clk);
            if (valid_t) begin nvalid++; last_p = 32'(period_t); last_h = 32'(high_t); end
            if (timeout_t) nto++;
        end
    endtask

    task automatic test_reset;
        #1;
        nvec++; if (meas_period !== 32'd0) begin nerr++; $display("FAIL reset_period: got %0d want 0", meas_period); end
        nvec++; if (meas_high !== 32'd0) begin nerr++; $display("FAIL reset_high: got %0d want 0", meas_high); end
        nvec++; if ({meas_valid, dropped, timeout} !== 3'b000) begin nerr++; $display("FAIL reset_flags: got %b want 000", {meas_valid, dropped, timeout}); end
        nvec++; if ({valid_t, dropped_t, timeout_t} !== 3'b000) begin nerr++; $display("FAIL reset_flags_t: got %b want 000", {valid_t, dropped_t, timeout_t}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_square;
        meas_ready = 1'b1;
        nvalid = 0; ndrop = 0;
        drive(1'b1, 5000); drive(1'b0, 5000);
        nvec++; if (nvalid !== 0) begin nerr++; $display("FAIL square_arm: got %0d results want 0", nvalid); end
        for (int i = 0; i < 2; i++) begin
            nvalid = 0;
            drive(1'b1, 5000); drive(1'b0, 5000);
            nvec++; if (nvalid !== 1) begin nerr++; $display("FAIL square_pulse: got %0d valid cycles want 1", nvalid); end
            nvec++; if (last_p !== 32'd10000) begin nerr++; $display("FAIL square_period: got %0d want 10000", last_p); end
            nvec++; if (last_h !== 32'd5000) begin nerr++; $display("FAIL square_high: got %0d want 5000", last_h); end
        end
        nvec++; if (ndrop !== 0) begin nerr++; $display("FAIL square_dropped: got %0d want 0", ndrop); end
    endtask

    task automatic test_asym;
        drive(1'b1, 3); drive(1'b0, 5);
        for (int i = 0; i < 4; i++) begin
            nvalid = 0;
            drive(1'b1, 3); drive(1'b0, 5);
            nvec++; if (nvalid !== 1 || last_p !== 32'd8 || last_h !== 32'd3) begin
                nerr++; $display("FAIL asym: got n=%0d p=%0d h=%0d want n=1 p=8 h=3", nvalid, last_p, last_h);
            end
        end
    endtask

    task automatic test_dropped;
        meas_ready = 1'b1;
        drive(1'b1, 5000); drive(1'b0, 5000);
        meas_ready = 1'b0;
        drive(1'b1, 4000);
        nvec++; if ({meas_valid, dropped} !== 2'b10) begin nerr++; $display("FAIL drop_first_flags: got %b want 10", {meas_valid, dropped}); end
        nvec++; if (meas_period !== 32'd10000 || meas_high !== 32'd5000) begin nerr++; $display("FAIL drop_first_val: got p=%0d h=%0d want p=10000 h=5000", meas_period, meas_high); end
        drive(1'b0, 6000); drive(1'b1, 10);
        nvec++; if ({meas_valid, dropped} !== 2'b11) begin nerr++; $display("FAIL drop_second_flags: got %b want 11", {meas_valid, dropped}); end
        nvec++; if (meas_period !== 32'd10000 || meas_high !== 32'd4000) begin nerr++; $display("FAIL drop_second_val: got p=%0d h=%0d want p=10000 h=4000", meas_period, meas_high); end
        meas_ready = 1'b1;
        @(negedge clk);
        meas_ready = 1'b0;
        nvec++; if ({meas_valid, dropped} !== 2'b00) begin nerr++; $display("FAIL drop_accept: got %b want 00", {meas_valid, dropped}); end
    endtask

    task automatic test_back_to_back;
        meas_ready = 1'b0;
        drive(1'b0, 6); drive(1'b1, 4); drive(1'b0, 6);
        nvec++; if ({meas_valid, dropped} !== 2'b10) begin nerr++; $display("FAIL b2b_held: got %b want 10", {meas_valid, dropped}); end
        sig_in = 1'b1;
        repeat (2) @(negedge clk);
        meas_ready = 1'b1;
        @(negedge clk);
        nvec++; if ({meas_valid, dropped} !== 2'b10) begin nerr++; $display("FAIL b2b_flags: got %b want 10", {meas_valid, dropped}); end
        nvec++; if (meas_period !== 32'd10 || meas_high !== 32'd4) begin nerr++; $display("FAIL b2b_val: got p=%0d h=%0d want p=10 h=4", meas_period, meas_high); end
        @(negedge clk);
        nvec++; if (meas_valid !== 1'b0) begin nerr++; $display("FAIL b2b_consumed: got %b want 0", meas_valid); end
    endtask

    task automatic test_midreset;
        meas_ready = 1'b0;
        drive(1'b0, 5); drive(1'b1, 20); drive(1'b0, 20); drive(1'b1, 20);
        nvec++; if (meas_valid !== 1'b1 || meas_period !== 32'd40) begin nerr++; $display("FAIL prereset: got v=%b p=%0d want v=1 p=40", meas_valid, meas_period); end
        #2 rst_n = 1'b0;
        #1;
        nvec++; if ({meas_period, meas_high} !== 64'd0) begin nerr++; $display("FAIL async_reset_val: got p=%0d h=%0d want 0 0", meas_period, meas_high); end
        nvec++; if ({meas_valid, dropped, timeout} !== 3'b000) begin nerr++; $display("FAIL async_reset_flags: got %b want 000", {meas_valid, dropped, timeout}); end
        sig_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        meas_ready = 1'b1;
        nvalid = 0;
        drive(1'b0, 5); drive(1'b1, 7); drive(1'b0, 5);
        nvec++; if (nvalid !== 0) begin nerr++; $display("FAIL reset_rearm: got %0d results want 0", nvalid); end
        drive(1'b1, 7); drive(1'b0, 5);
        nvec++; if (nvalid !== 1 || last_p !== 32'd12 || last_h !== 32'd7) begin
            nerr++; $display("FAIL reset_second: got n=%0d p=%0d h=%0d want n=1 p=12 h=7", nvalid, last_p, last_h);
        end
    endtask

    task automatic test_timeout;
        int first = 0;
        nvalid = 0; nto = 0;
        sig_t = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (timeout_t) begin nto++; if (first == 0) first = i; end
            if (valid_t) nvalid++;
        end
        nvec++; if (first !== 103) begin nerr++; $display("FAIL timeout_time: got %0d want 103", first); end
        nvec++; if (nto !== 1) begin nerr++; $display("FAIL timeout_count: got %0d want 1", nto); end
        nvec++; if (nvalid !== 0) begin nerr++; $display("FAIL timeout_nopub: got %0d want 0", nvalid); end
        drive_t(1'b0, 20); drive_t(1'b1, 20); drive_t(1'b0, 20); drive_t(1'b1, 10);
        nvec++; if (nvalid !== 1 || last_p !== 32'd40 || last_h !== 32'd20) begin
            nerr++; $display("FAIL timeout_rearm: got n=%0d p=%0d h=%0d want n=1 p=40 h=20", nvalid, last_p, last_h);
        end
        nvec++; if (nto !== 1) begin nerr++; $display("FAIL timeout_extra: got %0d want 1", nto); end
    endtask

    initial begin
        test_reset;
        test_square;
        test_asym;
        test_dropped;
        test_back_to_back;
        test_midreset;
        test_timeout;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
